// File: rtl/morph_gene_sequencer.sv
// Steps one external MorphologicUnit through a chromosome, one gene per clock,
// feeding each result back as the next image and publishing the final image.
module morph_gene_sequencer #(
  parameter int ImageWidth  = 32,
  parameter int ImageHeight = 32,
  parameter int GeneCount   = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic [ImageWidth*ImageHeight-1:0] img,
  input  logic [12*GeneCount-1:0]           chromosome,
  output logic                              busy,
  output logic                              done,
  output logic [ImageWidth*ImageHeight-1:0] result,
  output logic [ImageWidth*ImageHeight-1:0] muImg,
  output logic [8:0]                        muEl,
  output logic [2:0]                        muOp,
  input  logic [ImageWidth*ImageHeight-1:0] muResult
);
  localparam int PIX = ImageWidth * ImageHeight;
  localparam int IW  = (GeneCount > 1) ? $clog2(GeneCount) : 1;
  localparam logic [IW-1:0] LAST = IW'(GeneCount - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state;
  logic [PIX-1:0]               img_reg;
  logic [GeneCount-1:0][11:0]   chrom_reg;
  logic [IW-1:0]                gene_idx;
  logic [11:0]                  gene;

  // Gene select is a pure mux of registers, so nothing from muResult loops back to the unit.
  always_comb begin
    gene = '0;
    for (int i = 0; i < GeneCount; i++)
      if (gene_idx == IW'(i)) gene = chrom_reg[i];
  end

  assign muImg        = img_reg;
  assign {muOp, muEl} = (state == RUN) ? gene : 12'd0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      img_reg   <= '0;
      chrom_reg <= '0;
      gene_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            img_reg   <= img;
            chrom_reg <= chromosome;
            gene_idx  <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // Every gene costs one cycle, bypass genes included.
          img_reg <= muResult;
          if (gene_idx == LAST) begin
            result   <= muResult;
            done     <= 1'b1;
            busy     <= 1'b0;
            gene_idx <= '0;
            state    <= IDLE;
          end else begin
            gene_idx <= gene_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_morph_gene_sequencer.sv
// Bench for morph_gene_sequencer on 8x8 images with a behavioural stand-in for the
// MorphologicUnit (001 dilate, 010 erode, others pass through, zero padding).
module tb_morph_gene_sequencer;
  localparam int W = 8, H = 8, N = W * H;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;

  function automatic logic [N-1:0] morph(input logic [N-1:0] im, input logic [8:0] el,
                                         input logic [2:0] op);
    logic [N-1:0] o;
    o = im;
    if (op == 3'b001 || op == 3'b010) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          logic acc;
          acc = (op == 3'b010);
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if (el[(dr+1)*3 + (dc+1)]) begin
                logic px;
                px = 1'b0;
                if (r+dr >= 0 && r+dr < H && c+dc >= 0 && c+dc < W) px = im[(r+dr)*W + c+dc];
                if (op == 3'b001) acc = acc | px;
                else              acc = acc & px;
              end
          o[r*W + c] = acc;
        end
    end
    return o;
  endfunction

  function automatic logic [N-1:0] run_ref(input logic [N-1:0] im, input logic [95:0] ch,
                                           input int g);
    logic [N-1:0] cur;
    cur = im;
    for (int i = 0; i < g; i++) cur = morph(cur, ch[12*i +: 9], ch[12*i+9 +: 3]);
    return cur;
  endfunction

  // GeneCount=8 instance
  logic start8 = 1'b0, busy8, done8;
  logic [N-1:0] img8 = '0, res8, mu_img8, mu_res8;
  logic [95:0] chrom8 = '0;
  logic [8:0] mu_el8; logic [2:0] mu_op8;
  assign mu_res8 = morph(mu_img8, mu_el8, mu_op8);
  morph_gene_sequencer #(.ImageWidth(W), .ImageHeight(H), .GeneCount(8)) d8 (
    .clk(clk), .rstn(rstn), .start(start8), .img(img8), .chromosome(chrom8),
    .busy(busy8), .done(done8), .result(res8), .muImg(mu_img8), .muEl(mu_el8),
    .muOp(mu_op8), .muResult(mu_res8));

  // GeneCount=2 instance
  logic start2 = 1'b0, busy2, done2;
  logic [N-1:0] img2 = '0, res2, mu_img2, mu_res2;
  logic [23:0] chrom2 = '0;
  logic [8:0] mu_el2; logic [2:0] mu_op2;
  assign mu_res2 = morph(mu_img2, mu_el2, mu_op2);
  morph_gene_sequencer #(.ImageWidth(W), .ImageHeight(H), .GeneCount(2)) d2 (
    .clk(clk), .rstn(rstn), .start(start2), .img(img2), .chromosome(chrom2),
    .busy(busy2), .done(done2), .result(res2), .muImg(mu_img2), .muEl(mu_el2),
    .muOp(mu_op2), .muResult(mu_res2));

  // GeneCount=1 instance
  logic start1 = 1'b0, busy1, done1;
  logic [N-1:0] img1 = '0, res1, mu_img1, mu_res1;
  logic [11:0] chrom1 = '0;
  logic [8:0] mu_el1; logic [2:0] mu_op1;
  assign mu_res1 = morph(mu_img1, mu_el1, mu_op1);
  morph_gene_sequencer #(.ImageWidth(W), .ImageHeight(H), .GeneCount(1)) d1 (
    .clk(clk), .rstn(rstn), .start(start1), .img(img1), .chromosome(chrom1),
    .busy(busy1), .done(done1), .result(res1), .muImg(mu_img1), .muEl(mu_el1),
    .muOp(mu_op1), .muResult(mu_res1));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full GeneCount=8 run: gene presented each cycle, done after the 8th RUN edge.
  task automatic run8(input logic [N-1:0] im, input logic [95:0] ch, input string tag);
    logic [N-1:0] exp;
    exp = run_ref(im, ch, 8);
    img8 = im; chrom8 = ch; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_busy"}, N'(busy8), N'(1'b1));
      chk({tag, "_done_early"}, N'(done8), N'(1'b0));
      chk({tag, "_op"}, N'(mu_op8), N'(ch[12*k+9 +: 3]));
      chk({tag, "_el"}, N'(mu_el8), N'(ch[12*k +: 9]));
      tick();
    end
    chk({tag, "_done"}, N'(done8), N'(1'b1));
    chk({tag, "_busy_end"}, N'(busy8), N'(1'b0));
    chk({tag, "_result"}, res8, exp);
    tick();
    chk({tag, "_done_drop"}, N'(done8), N'(1'b0));
  endtask

  initial begin
    logic [N-1:0] im, im_b, exp_blk, exp_er;
    logic [95:0]  ch, ch_b;
    int ndone;

    // 1: reset
    rstn = 1'b0;
    tick(); tick();
    chk("rst_busy", N'(busy8), '0);
    chk("rst_done", N'(done8), '0);
    chk("rst_result", res8, '0);
    chk("rst_op", N'(mu_op8), '0);
    chk("rst_el", N'(mu_el8), '0);
    chk("rst_result2", res2, '0);
    chk("rst_result1", res1, '0);
    rstn = 1'b1;
    tick();

    // 2: GeneCount=2, dilate a single pixel then bypass
    img2 = '0; img2[4*W + 4] = 1'b1;
    chrom2 = {12'h000, 3'b001, 9'h1FF};
    exp_blk = '0;
    for (int r = 3; r <= 5; r++) for (int c = 3; c <= 5; c++) exp_blk[r*W + c] = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("g2_busy_t1", N'(busy2), N'(1'b1));
    tick();
    chk("g2_busy_t2", N'(busy2), N'(1'b1));
    chk("g2_done_early", N'(done2), N'(1'b0));
    tick();
    chk("g2_done", N'(done2), N'(1'b1));
    chk("g2_busy_end", N'(busy2), N'(1'b0));
    chk("g2_result", res2, exp_blk);
    tick();
    chk("g2_done_drop", N'(done2), N'(1'b0));

    // 3: all bypass genes return the source image
    im = {$urandom, $urandom};
    ch = '0;
    for (int i = 0; i < 8; i++) ch[12*i +: 9] = 9'($urandom);
    run8(im, ch, "bypass");
    chk("bypass_identity", res8, im);

    // random chromosomes against the reference
    for (int t = 0; t < 4; t++) begin
      im = {$urandom, $urandom};
      ch = {$urandom, $urandom, $urandom};
      run8(im, ch, "rand");
    end

    // 4: start held, inputs changed mid-run, restart from the done cycle
    im = {$urandom, $urandom}; ch = {$urandom, $urandom, $urandom};
    im_b = {$urandom, $urandom}; ch_b = {$urandom, $urandom, $urandom};
    img8 = im; chrom8 = ch; start8 = 1'b1;
    tick();
    ndone = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin img8 = im_b; chrom8 = ch_b; end
      tick();
      if (done8) ndone++;
    end
    chk("held_done_count", N'(ndone), N'(1));
    chk("held_done_last", N'(done8), N'(1'b1));
    chk("held_result", res8, run_ref(im, ch, 8));
    tick();
    start8 = 1'b0;
    chk("restart_busy", N'(busy8), N'(1'b1));
    chk("restart_done_drop", N'(done8), N'(1'b0));
    for (int k = 1; k <= 8; k++) tick();
    chk("restart_done", N'(done8), N'(1'b1));
    chk("restart_result", res8, run_ref(im_b, ch_b, 8));
    tick();

    // 5: reset while gene 1 is active
    img8 = {$urandom, $urandom}; chrom8 = {$urandom, $urandom, $urandom}; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    chk("abort_pre_op", N'(mu_op8), N'(chrom8[21 +: 3]));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("abort_busy", N'(busy8), '0);
    chk("abort_done", N'(done8), '0);
    chk("abort_result", res8, '0);
    chk("abort_op", N'(mu_op8), '0);
    ndone = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (done8) ndone++; end
    chk("abort_no_done", N'(ndone), '0);
    run8({$urandom, $urandom}, {$urandom, $urandom, $urandom}, "after_abort");

    // 6: GeneCount=1 erode of an all-ones image
    img1 = '1;
    chrom1 = {3'b010, 9'h1FF};
    exp_er = '0;
    for (int r = 1; r <= 6; r++) for (int c = 1; c <= 6; c++) exp_er[r*W + c] = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("g1_busy", N'(busy1), N'(1'b1));
    chk("g1_op", N'(mu_op1), N'(3'b010));
    tick();
    chk("g1_done", N'(done1), N'(1'b1));
    chk("g1_busy_end", N'(busy1), N'(1'b0));
    chk("g1_result", res1, exp_er);
    tick();
    chk("g1_done_drop", N'(done1), N'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
